// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encodings, bluetooth command
// bytes, game-state codes and a small bluetooth decode helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        GS_INIT  = 3'd0,
        GS_GAME  = 3'd1,
        GS_START = 3'd2,
        GS_LOSE  = 3'd3,
        GS_WIN   = 3'd4
    } game_state_t;

    localparam logic [7:0] BT_UP    = 8'h55;
    localparam logic [7:0] BT_LEFT  = 8'h48;
    localparam logic [7:0] BT_DOWN  = 8'h4A;
    localparam logic [7:0] BT_RIGHT = 8'h4B;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } bt_cmd_t;

    // Map a received byte onto a direction; valid is low for any other byte.
    function automatic bt_cmd_t bt_decode(input logic [7:0] b);
        bt_cmd_t r;
        r.valid = 1'b1;
        r.dir   = DIR_RIGHT;
        case (b)
            BT_UP:    r.dir = DIR_UP;
            BT_LEFT:  r.dir = DIR_LEFT;
            BT_DOWN:  r.dir = DIR_DOWN;
            BT_RIGHT: r.dir = DIR_RIGHT;
            default:  r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Opposite heading: flipping bit 1 swaps right/left and down/up.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, counter debouncer and rising-edge detector for one
// raw push button. press pulses for one clk when the debounced level rises.
import snake_pkg::*;

module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic [CW-1:0] count;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive samples that disagree with the debounced level; flip on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                level <= sync_q2;
                press <= sync_q2;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dir_cmd_scheduler.sv
// Snake direction command scheduler: merges debounced board buttons and
// bluetooth bytes into one command per cycle, filters no-op and reversing
// turns, and queues accepted turns so each step_tick applies the next one.
import snake_pkg::*;

module dir_cmd_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DEPTH           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       right,
    input  logic       down,
    input  logic       left,
    input  logic       up,
    input  logic [7:0] bluetooth_data,
    input  logic       step_tick,
    input  logic       game_active,
    output logic [1:0] new_direction,
    output logic [3:0] pending,
    output logic       cmd_accept,
    output logic       cmd_drop
);

    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DEPTH_CNT = 4'(DEPTH);

    // Bit index equals the direction code of that button.
    logic [3:0] buttons;
    logic [3:0] press;

    assign buttons = {up, left, down, right};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .button (buttons[i]),
            .press  (press[i])
        );
    end

    logic [7:0] bt_prev;
    bt_cmd_t    bt_dec;
    logic       bt_new;

    assign bt_dec = bt_decode(bluetooth_data);
    assign bt_new = bt_dec.valid && (bluetooth_data != bt_prev);

    // Remember the last recognised bluetooth code, even if its command loses or is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bt_prev <= '0;
        end else if (bt_dec.valid) begin
            bt_prev <= bluetooth_data;
        end
    end

    logic cmd_valid;
    dir_t cmd_dir;

    // Fixed-priority pick of at most one command per cycle.
    always_comb begin
        cmd_valid = 1'b1;
        cmd_dir   = DIR_RIGHT;
        if (press[0]) begin
            cmd_dir = DIR_RIGHT;
        end else if (press[1]) begin
            cmd_dir = DIR_DOWN;
        end else if (press[2]) begin
            cmd_dir = DIR_LEFT;
        end else if (press[3]) begin
            cmd_dir = DIR_UP;
        end else if (bt_new) begin
            cmd_dir = bt_dec.dir;
        end else begin
            cmd_valid = 1'b0;
        end
    end

    dir_t          fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    count;
    dir_t          ref_dir;
    logic          full;
    logic          cmd_ok;
    logic          push;
    logic          pop;
    logic          drop;

    // Turn filter against the heading the snake will have when this command runs, plus queue control.
    always_comb begin
        ref_dir = (count != '0) ? fifo_mem[wr_ptr - PW'(1)] : dir_t'(new_direction);
        full    = (count == DEPTH_CNT);
        cmd_ok  = cmd_valid && game_active &&
                  (cmd_dir != ref_dir) && (cmd_dir != dir_reverse(ref_dir));
        pop     = game_active && step_tick && (count != '0);
        // A tick on a full queue frees the head slot in the same edge, so the push still fits.
        push    = cmd_ok && (!full || step_tick);
        drop    = cmd_ok && full && !step_tick;
    end

    // Queue storage; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_dir;
        end
    end

    // Pointers, occupancy, applied direction and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            new_direction <= DIR_RIGHT;
            cmd_accept    <= 1'b0;
            cmd_drop      <= 1'b0;
        end else begin
            cmd_accept <= push;
            cmd_drop   <= drop;
            if (!game_active) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                count         <= '0;
                new_direction <= DIR_RIGHT;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr        <= rd_ptr + PW'(1);
                    new_direction <= fifo_mem[rd_ptr];
                end
                case ({push, pop})
                    2'b10:   count <= count + 4'd1;
                    2'b01:   count <= count - 4'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign pending = count;

endmodule

// File: tb/tb_dir_cmd_scheduler.sv
// Directed bench for dir_cmd_scheduler with a behavioural reference model
// compared every cycle, plus hand-computed expectations per scenario.
module tb_dir_cmd_scheduler;

    localparam int unsigned DEB   = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       right, down, left, up;
    logic [7:0] bluetooth_data;
    logic       step_tick;
    logic       game_active;
    logic [1:0] new_direction;
    logic [3:0] pending;
    logic       cmd_accept;
    logic       cmd_drop;

    int checks = 0;
    int errors = 0;
    int acc_seen;
    int drop_seen;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dir_cmd_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .right          (right),
        .down           (down),
        .left           (left),
        .up             (up),
        .bluetooth_data (bluetooth_data),
        .step_tick      (step_tick),
        .game_active    (game_active),
        .new_direction  (new_direction),
        .pending        (pending),
        .cmd_accept     (cmd_accept),
        .cmd_drop       (cmd_drop)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. A button's level flips once it has been sampled at
    // the new value DEB times in a row; a rising flip becomes a command three
    // edges later (two synchroniser stages plus the registered press pulse).
    logic [3:0]  m_lvl, m_val;
    int unsigned m_run [4];
    logic [3:0]  m_p0, m_p1, m_p2;
    logic [7:0]  m_prev;
    logic [1:0]  m_q [$];
    logic [1:0]  m_dir;
    logic        m_acc, m_drop;

    always @(posedge clk or posedge rst) begin
        logic [3:0] raw, ev, now;
        logic       have, bt_ok, bt_new, push;
        logic [1:0] c, refd, bt_d;
        if (rst) begin
            m_lvl = '0; m_val = '0; m_p0 = '0; m_p1 = '0; m_p2 = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_prev = 8'h00; m_q.delete(); m_dir = 2'b00; m_acc = 1'b0; m_drop = 1'b0;
        end else begin
            raw = {up, left, down, right};
            ev  = '0;
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == m_val[i]) m_run[i]++;
                else begin m_val[i] = raw[i]; m_run[i] = 1; end
                if (m_run[i] == DEB && raw[i] != m_lvl[i]) begin
                    m_lvl[i] = raw[i];
                    ev[i]    = raw[i];
                end
            end
            now = m_p2; m_p2 = m_p1; m_p1 = m_p0; m_p0 = ev;

            bt_ok = 1'b1; bt_d = 2'd0;
            case (bluetooth_data)
                8'h55:   bt_d = 2'd3;
                8'h48:   bt_d = 2'd2;
                8'h4A:   bt_d = 2'd1;
                8'h4B:   bt_d = 2'd0;
                default: bt_ok = 1'b0;
            endcase
            bt_new = bt_ok && (bluetooth_data != m_prev);
            if (bt_ok) m_prev = bluetooth_data;

            have = 1'b0; c = 2'd0;
            for (int i = 0; i < 4; i++)
                if (!have && now[i]) begin have = 1'b1; c = 2'(i); end
            if (!have && bt_new) begin have = 1'b1; c = bt_d; end

            m_acc = 1'b0; m_drop = 1'b0; push = 1'b0;
            if (!game_active) begin
                m_q.delete();
                m_dir = 2'b00;
            end else begin
                refd = (m_q.size() > 0) ? m_q[$] : m_dir;
                if (have && c != refd && c != (refd ^ 2'b10)) begin
                    if (m_q.size() < int'(DEPTH) || step_tick) push = 1'b1;
                    else m_drop = 1'b1;
                end
                if (step_tick && m_q.size() > 0) m_dir = m_q.pop_front();
                if (push) begin m_q.push_back(c); m_acc = 1'b1; end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model new_direction", int'(new_direction), int'(m_dir));
            check("model pending", int'(pending), m_q.size());
            check("model cmd_accept", int'(cmd_accept), int'(m_acc));
            check("model cmd_drop", int'(cmd_drop), int'(m_drop));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            acc_seen  += int'(cmd_accept);
            drop_seen += int'(cmd_drop);
        end
    endtask

    task automatic tick_check(input string name, input int exp_dir, input int exp_pend);
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        check({name, " dir"}, int'(new_direction), exp_dir);
        check({name, " pending"}, int'(pending), exp_pend);
    endtask

    task automatic send(input logic [7:0] b, input int n);
        bluetooth_data = b;
        cyc(n);
    endtask

    initial begin
        rst = 1'b1;
        right = 1'b0; down = 1'b0; left = 1'b0; up = 1'b0;
        bluetooth_data = 8'h00; step_tick = 1'b0; game_active = 1'b0;
        acc_seen = 0; drop_seen = 0;
        @(negedge clk);
        chk_en = 1'b1;
        cyc(2);
        check("reset new_direction", int'(new_direction), 0);
        check("reset pending", int'(pending), 0);
        check("reset cmd_accept", int'(cmd_accept), 0);
        check("reset cmd_drop", int'(cmd_drop), 0);
        rst = 1'b0; game_active = 1'b1;
        cyc(2);

        // Held down button: one command only, applied on the next tick.
        acc_seen = 0; drop_seen = 0;
        down = 1'b1; cyc(14); down = 1'b0; cyc(14);
        check("down press accepts", acc_seen, 1);
        check("down press drops", drop_seen, 0);
        check("down press pending", int'(pending), 1);
        check("down press dir before tick", int'(new_direction), 0);
        tick_check("down tick", 1, 0);

        // Back to heading right, then a reversing button and a same-direction byte.
        game_active = 1'b0; cyc(2);
        check("inactive pending", int'(pending), 0);
        check("inactive dir", int'(new_direction), 0);
        game_active = 1'b1; cyc(1);
        acc_seen = 0; drop_seen = 0;
        left = 1'b1; cyc(14); left = 1'b0; cyc(14);
        send(8'h4B, 3);
        check("rejected accepts", acc_seen, 0);
        check("rejected drops", drop_seen, 0);
        check("rejected pending", int'(pending), 0);

        // Fill the queue, then overflow once.
        acc_seen = 0; drop_seen = 0;
        send(8'h4A, 2); send(8'h48, 2); send(8'h55, 2); send(8'h4B, 2); send(8'h4A, 2);
        check("fill accepts", acc_seen, 4);
        check("fill drops", drop_seen, 1);
        check("fill pending", int'(pending), 4);
        check("fill dir", int'(new_direction), 0);

        // Push and tick together on a full queue.
        acc_seen = 0; drop_seen = 0;
        bluetooth_data = 8'h55; step_tick = 1'b1; cyc(1); step_tick = 1'b0; cyc(2);
        check("full push+tick accepts", acc_seen, 1);
        check("full push+tick drops", drop_seen, 0);
        check("full push+tick pending", int'(pending), 4);
        check("full push+tick dir", int'(new_direction), 1);
        tick_check("drain 1", 2, 3);
        tick_check("drain 2", 3, 2);
        tick_check("drain 3", 0, 1);
        tick_check("drain 4", 3, 0);

        // Short glitch, repeated byte, and an unknown byte between repeats.
        acc_seen = 0; drop_seen = 0;
        right = 1'b1; cyc(4); right = 1'b0; cyc(14);
        send(8'h48, 2); send(8'h48, 2); send(8'h00, 2); send(8'h48, 2);
        check("glitch/repeat accepts", acc_seen, 1);
        check("glitch/repeat pending", int'(pending), 1);

        // Right and down at once: right wins, is a reversal of left, down is lost.
        acc_seen = 0; drop_seen = 0;
        right = 1'b1; down = 1'b1; cyc(14); right = 1'b0; down = 1'b0; cyc(14);
        check("priority accepts", acc_seen, 0);
        check("priority pending", int'(pending), 1);

        // Inactive game flushes and ignores, but still tracks the previous byte.
        game_active = 1'b0; cyc(2);
        check("flush pending", int'(pending), 0);
        check("flush dir", int'(new_direction), 0);
        send(8'h4A, 2);
        game_active = 1'b1; cyc(2);
        acc_seen = 0;
        send(8'h4A, 3);
        check("tracked byte accepts", acc_seen, 0);

        // Reset mid-queue and mid-debounce.
        send(8'h55, 2); send(8'h48, 2); send(8'h4A, 2); send(8'h4B, 2);
        tick_check("pre-reset tick", 3, 3);
        up = 1'b1; cyc(5);
        @(posedge clk); #3; rst = 1'b1; #1;
        check("async reset dir", int'(new_direction), 0);
        check("async reset pending", int'(pending), 0);
        check("async reset accept", int'(cmd_accept), 0);
        check("async reset drop", int'(cmd_drop), 0);
        cyc(2);
        rst = 1'b0;
        acc_seen = 0; drop_seen = 0;
        cyc(14); up = 1'b0; cyc(14);
        check("post-reset accepts", acc_seen, 1);
        check("post-reset pending", int'(pending), 1);
        check("post-reset dir", int'(new_direction), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
